// File: rtl/bpromotion_sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : bpromotion_sprite_fetch_if
// Purpose  : Pixel-side, menu-control and sprite-ROM signals of the black
//            pawn-promotion menu sprite fetch stage, bundled for port use.
// Revision : 1.0 - initial release
// ============================================================================
interface bpromotion_sprite_fetch_if #(
  parameter int ADDR_W = 13
);
  // Raster position from the VGA controller
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              vis_in;
  // Promotion-menu request from the game FSM
  logic              menu_show;
  logic [9:0]        menu_x;
  logic [9:0]        menu_y;
  logic [1:0]        sel;
  // Synchronous sprite ROM
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  // Towards the palette stage
  logic [3:0]        index;
  logic              pixel_hit;
  logic              vis_out;

  // The fetch stage itself
  modport slave (
    input  DrawX, DrawY, vis_in, menu_show, menu_x, menu_y, sel, rom_data,
    output rom_addr, index, pixel_hit, vis_out
  );

  // Raster source, game FSM and ROM side
  modport master (
    output DrawX, DrawY, vis_in, menu_show, menu_x, menu_y, sel, rom_data,
    input  rom_addr, index, pixel_hit, vis_out
  );
endinterface
`default_nettype wire

// File: rtl/bpromotion_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : bpromotion_sprite_fetch
// Purpose  : Promotion-menu sprite fetch. Hit-tests the raster position
//            against a frame-latched menu rectangle, addresses the sprite ROM
//            and aligns the returned colour index with hit / highlight /
//            visibility flags. Output latency is 2 clocks from DrawX/DrawY.
// Revision : 1.0 - initial release
// ============================================================================
module bpromotion_sprite_fetch #(
  parameter int         MENU_W       = 160,
  parameter int         MENU_H       = 40,
  parameter int         SLOT_W       = 40,
  parameter int         ADDR_W       = 13,
  parameter logic [3:0] HL_INDEX     = 4'h1,
  parameter int         BLINK_FRAMES = 30
) (
  input  wire logic                   Clk,
  input  wire logic                   Reset_n,
  bpromotion_sprite_fetch_if.slave    bus
);

  // Blink counter needs at least one bit even when BLINK_FRAMES is 1
  localparam int c_cnt_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLINK_FRAMES - 1);

  // Frame-latched menu state (no tearing within a frame)
  logic               r_show;
  logic [9:0]         r_mx;
  logic [9:0]         r_my;
  logic [1:0]         r_sel;
  logic [c_cnt_w-1:0] r_blink_cnt;
  logic               r_blink_phase;

  // Pipeline registers
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_hit1;
  logic               r_border1;
  logic               r_vis1;
  logic               r_hit2;
  logic               r_border2;
  logic               r_vis2;

  // Stage-0 combinational terms, all in 11-bit unsigned so menu+size never wraps
  logic [10:0]        w_x;
  logic [10:0]        w_y;
  logic [10:0]        w_mx;
  logic [10:0]        w_my;
  logic [10:0]        w_x_end;
  logic [10:0]        w_y_end;
  logic [10:0]        w_rx;
  logic [10:0]        w_ry;
  logic [10:0]        w_lx;
  logic [10:0]        w_slot_base;
  logic [1:0]         w_slot;
  logic               w_frame_start;
  logic               w_hit0;
  logic               w_edge;
  logic               w_border0;
  logic [ADDR_W-1:0]  w_addr0;

  assign w_frame_start = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);

  assign w_x     = {1'b0, bus.DrawX};
  assign w_y     = {1'b0, bus.DrawY};
  assign w_mx    = {1'b0, r_mx};
  assign w_my    = {1'b0, r_my};
  assign w_x_end = w_mx + 11'(MENU_W);
  assign w_y_end = w_my + 11'(MENU_H);
  assign w_rx    = w_x - w_mx;
  assign w_ry    = w_y - w_my;

  // Menu rectangle test; clipping past the screen edge falls out naturally
  assign w_hit0 = r_show & bus.vis_in
                & (w_x >= w_mx) & (w_x < w_x_end)
                & (w_y >= w_my) & (w_y < w_y_end);

  // Slot number by threshold compares instead of a divider
  always_comb begin
    w_slot      = 2'd3;
    w_slot_base = 11'(3 * SLOT_W);
    if (w_rx < 11'(SLOT_W)) begin
      w_slot      = 2'd0;
      w_slot_base = 11'd0;
    end else if (w_rx < 11'(2 * SLOT_W)) begin
      w_slot      = 2'd1;
      w_slot_base = 11'(SLOT_W);
    end else if (w_rx < 11'(3 * SLOT_W)) begin
      w_slot      = 2'd2;
      w_slot_base = 11'(2 * SLOT_W);
    end
  end

  assign w_lx = w_rx - w_slot_base;

  // Two-pixel frame around the selected slot
  assign w_edge = (w_lx < 11'd2) | (w_lx >= 11'(SLOT_W - 2))
                | (w_ry < 11'd2) | (w_ry >= 11'(MENU_H - 2));

  assign w_border0 = w_hit0 & (w_slot == r_sel) & w_edge & r_blink_phase;

  // Row-major sprite address, truncated to the ROM width
  assign w_addr0 = ADDR_W'(w_ry) * ADDR_W'(MENU_W) + ADDR_W'(w_rx);

  // Frame-start capture of menu state and blink timing
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_show        <= 1'b0;
      r_mx          <= 10'd0;
      r_my          <= 10'd0;
      r_sel         <= 2'd0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_start) begin
      r_show <= bus.menu_show;
      r_mx   <= bus.menu_x;
      r_my   <= bus.menu_y;
      r_sel  <= bus.sel;
      if (r_blink_cnt == c_cnt_last) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Stage 0: ROM address and first copy of the pixel flags
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_hit1     <= 1'b0;
      r_border1  <= 1'b0;
      r_vis1     <= 1'b0;
    end else begin
      r_rom_addr <= w_hit0 ? w_addr0 : '0;
      r_hit1     <= w_hit0;
      r_border1  <= w_border0;
      r_vis1     <= bus.vis_in;
    end
  end

  // Stage 1: flags delayed to line up with the ROM's registered data
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_hit2    <= 1'b0;
      r_border2 <= 1'b0;
      r_vis2    <= 1'b0;
    end else begin
      r_hit2    <= r_hit1;
      r_border2 <= r_border1;
      r_vis2    <= r_vis1;
    end
  end

  // Output mux: highlight border overrides the sprite colour
  always_comb begin
    bus.index = 4'h0;
    if (r_hit2) begin
      bus.index = r_border2 ? HL_INDEX : bus.rom_data;
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.pixel_hit = r_hit2;
  assign bus.vis_out   = r_vis2;

endmodule
`default_nettype wire

// File: tb/tb_bpromotion_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpromotion_sprite_fetch
// Purpose  : Self-checking bench: directed pins plus randomized raster/menu
//            traffic compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpromotion_sprite_fetch;

  localparam int MENU_W = 160;
  localparam int MENU_H = 40;
  localparam int SLOT_W = 40;
  localparam int ADDR_W = 13;
  localparam int BLINK  = 2;
  localparam int HL     = 1;
  localparam int MAXC   = 8192;

  logic clk = 1'b0;
  logic Reset_n;
  always #5 clk = ~clk;

  bpromotion_sprite_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  bpromotion_sprite_fetch #(
    .MENU_W(MENU_W), .MENU_H(MENU_H), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W),
    .HL_INDEX(4'h1), .BLINK_FRAMES(BLINK)
  ) dut (
    .Clk    (clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  // Sprite ROM content: arbitrary but address-dependent
  function automatic logic [3:0] rom_fn(input int a);
    return 4'((a * 37 + (a >> 4)) ^ (a >> 9));
  endfunction

  // Synchronous ROM: data one clock after the address
  always @(posedge clk) bus.rom_data <= rom_fn(int'(bus.rom_addr));

  // Model state
  int   m_show, m_x, m_y, m_sel, m_fs;
  int   cur = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   running = 1'b0;
  bit   rec_rst [MAXC];
  bit   rec_hit [MAXC];
  bit   rec_bord[MAXC];
  bit   rec_vis [MAXC];
  int   rec_addr[MAXC];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cur);
    end
  endtask

  // Apply one pixel cycle, record what the model says it must produce,
  // then advance the frame-level model state and the clock.
  task automatic drive(input bit rn, input int x, input int y, input bit v,
                       input bit show, input int mx, input int my, input int s);
    int  rx, ry;
    bit  h, b;
    Reset_n       = rn;
    bus.DrawX     = 10'(x);
    bus.DrawY     = 10'(y);
    bus.vis_in    = v;
    bus.menu_show = show;
    bus.menu_x    = 10'(mx);
    bus.menu_y    = 10'(my);
    bus.sel       = 2'(s);
    rx = x - m_x;
    ry = y - m_y;
    h  = (m_show != 0) && v && x >= m_x && x < m_x + MENU_W
         && y >= m_y && y < m_y + MENU_H;
    b  = h && (rx / SLOT_W) == m_sel && ((m_fs / BLINK) % 2 == 1)
         && ((rx % SLOT_W) < 2 || (rx % SLOT_W) >= SLOT_W - 2
             || ry < 2 || ry >= MENU_H - 2);
    rec_rst[cur]  = !rn;
    rec_hit[cur]  = h;
    rec_bord[cur] = b;
    rec_vis[cur]  = v;
    rec_addr[cur] = h ? (ry * MENU_W + rx) % (1 << ADDR_W) : 0;
    if (!rn) begin
      m_show = 0; m_x = 0; m_y = 0; m_sel = 0; m_fs = 0;
    end else if (x == 0 && y == 0) begin
      m_show = show; m_x = mx; m_y = my; m_sel = s; m_fs++;
    end
    @(posedge clk);
    cur++;
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 700, 5, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Every-cycle comparison against the model (2-cycle pixel latency)
  always @(negedge clk) begin
    if (running && cur >= 2) begin
      int  k1, k2, e_addr, e_idx;
      bit  e_hit, e_vis;
      k1 = cur - 1;
      k2 = cur - 2;
      e_addr = rec_rst[k1] ? 0 : rec_addr[k1];
      e_hit  = !(rec_rst[k1] || rec_rst[k2]) && rec_hit[k2];
      e_vis  = !(rec_rst[k1] || rec_rst[k2]) && rec_vis[k2];
      e_idx  = !e_hit ? 0 : (rec_bord[k2] ? HL : int'(rom_fn(rec_addr[k2])));
      chk("model rom_addr",  int'(bus.rom_addr),  e_addr);
      chk("model pixel_hit", int'(bus.pixel_hit), int'(e_hit));
      chk("model vis_out",   int'(bus.vis_out),   int'(e_vis));
      chk("model index",     int'(bus.index),     e_idx);
    end
  end

  initial begin
    m_show = 0; m_x = 0; m_y = 0; m_sel = 0; m_fs = 0;
    running = 1'b1;

    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) drive(1'b0, 250, 230, 1'b1, 1'b1, 240, 220, 0);
    chk("reset rom_addr",  int'(bus.rom_addr), 0);
    chk("reset pixel_hit", int'(bus.pixel_hit), 0);
    chk("reset vis_out",   int'(bus.vis_out), 0);
    chk("reset index",     int'(bus.index), 0);

    // Released mid-frame with the menu requested: still dark until frame start
    for (int i = 0; i < 3; i++) drive(1'b1, 250, 230, 1'b1, 1'b1, 240, 220, 0);
    chk("midframe pixel_hit", int'(bus.pixel_hit), 0);
    chk("midframe rom_addr",  int'(bus.rom_addr), 0);
    chk("midframe index",     int'(bus.index), 0);

    // Frame 1: menu at (240,220), sel 0, blink phase 0
    drive(1'b1, 0, 0, 1'b1, 1'b1, 240, 220, 0);
    drive(1'b1, 240, 220, 1'b1, 1'b1, 240, 220, 0);
    chk("corner tl rom_addr", int'(bus.rom_addr), 0);
    drive(1'b1, 399, 259, 1'b1, 1'b1, 240, 220, 0);
    chk("corner br rom_addr", int'(bus.rom_addr), 6399);
    chk("corner tl pixel_hit", int'(bus.pixel_hit), 1);
    chk("corner tl index", int'(bus.index), int'(rom_fn(0)));
    drive(1'b1, 239, 220, 1'b1, 1'b1, 240, 220, 0);
    chk("left miss rom_addr", int'(bus.rom_addr), 0);
    chk("corner br pixel_hit", int'(bus.pixel_hit), 1);
    chk("corner br index", int'(bus.index), int'(rom_fn(6399)));
    drive(1'b1, 400, 259, 1'b1, 1'b1, 240, 220, 0);
    chk("right miss rom_addr", int'(bus.rom_addr), 0);
    chk("left miss pixel_hit", int'(bus.pixel_hit), 0);
    idle();
    chk("right miss pixel_hit", int'(bus.pixel_hit), 0);
    chk("right miss index", int'(bus.index), 0);

    // Frame 2: sel 2, blink phase toggles to 1 -> border on slot 2
    drive(1'b1, 0, 0, 1'b1, 1'b1, 240, 220, 2);
    drive(1'b1, 320, 225, 1'b1, 1'b1, 240, 220, 2);
    chk("slot2 rom_addr", int'(bus.rom_addr), 880);
    idle();
    chk("blink frame2 index", int'(bus.index), 1);
    // Frame 3: phase stays 1
    drive(1'b1, 0, 0, 1'b1, 1'b1, 240, 220, 2);
    drive(1'b1, 320, 225, 1'b1, 1'b1, 240, 220, 2);
    idle();
    chk("blink frame3 index", int'(bus.index), 1);
    // Frame 4: phase back to 0 -> ROM colour shows
    drive(1'b1, 0, 0, 1'b1, 1'b1, 240, 220, 2);
    drive(1'b1, 320, 225, 1'b1, 1'b1, 240, 220, 2);
    idle();
    chk("blink frame4 index", int'(bus.index), int'(rom_fn(880)));

    // Frame 5: menu at x=600 runs off the right edge
    drive(1'b1, 0, 0, 1'b1, 1'b1, 600, 220, 0);
    drive(1'b1, 639, 230, 1'b1, 1'b1, 600, 220, 0);
    chk("clip rom_addr", int'(bus.rom_addr), 1639);
    drive(1'b1, 0, 231, 1'b1, 1'b1, 600, 220, 0);
    chk("wrap rom_addr", int'(bus.rom_addr), 0);
    chk("clip pixel_hit", int'(bus.pixel_hit), 1);
    // Mid-frame menu_x change is ignored
    drive(1'b1, 639, 230, 1'b1, 1'b1, 100, 220, 0);
    chk("wrap pixel_hit", int'(bus.pixel_hit), 0);
    chk("tear rom_addr", int'(bus.rom_addr), 1639);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      bit rn, v;
      rn = ($urandom_range(0, 299) != 0);
      v  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 11) == 0) begin
        x = 0; y = 0;
      end else if ($urandom_range(0, 3) != 0) begin
        x = int'((m_x + $urandom_range(0, 165) - 3) & 1023);
        y = int'((m_y + $urandom_range(0, 45) - 3) & 1023);
      end else begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end
      drive(rn, x, y, v, ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 3)));
    end
    idle();
    idle();
    idle();
    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
